// File: rtl/spm_ctrl.sv
// Sequencer for a serial/parallel multiplier: latches (a, x), streams x LSB first, and deserialises the product.
// Latency: out_valid rises 2*bits+1 cycles after the accept edge; the minimum period is 2*bits+3 cycles.
// Backpressure: in_ready is high only in IDLE; the product is held in DONE until out_ready is seen.
// Optional feature SPM_CTRL_ACCUM_EN: adds in_acc/acc_ovf and accumulates products into out_p.
module spm_ctrl #(
    parameter int bits = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [bits-1:0]     in_a,
    input  logic [bits-1:0]     in_x,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*bits-1:0]   out_p,
    output logic                busy,
    output logic                spm_rst,
    output logic [bits-1:0]     spm_a,
    output logic                spm_x,
    input  logic                spm_y
`ifdef SPM_CTRL_ACCUM_EN
    ,
    input  logic                in_acc,
    output logic                acc_ovf
`endif
);

    // Counter must reach 2*bits, the last RUN cycle.
    localparam int CW = $clog2(2 * bits + 1);
    localparam int XW = (bits > 1) ? $clog2(bits) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * bits);
    localparam logic [CW-1:0] CNT_BITS = CW'(bits);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CW-1:0]       cnt;
    logic [bits-1:0]     a_reg;
    logic [bits-1:0]     x_reg;
    // Holds product bits 0..2*bits-2; the top bit arrives on spm_y at the final edge.
    logic [2*bits-2:0]   shreg;
    logic [2*bits-1:0]   prod_next;

    assign prod_next = {spm_y, shreg};
    assign spm_a     = a_reg;

`ifdef SPM_CTRL_ACCUM_EN
    logic                acc_reg;
    logic [2*bits:0]     acc_sum;

    assign acc_sum = {1'b0, out_p} + {1'b0, prod_next};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived handshake/serial outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        spm_x      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt < CNT_BITS) begin
                    spm_x = x_reg[cnt[XW-1:0]];
                end
                if (cnt == CNT_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand latch, bit counter, product deserialiser and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            a_reg   <= '0;
            x_reg   <= '0;
            shreg   <= '0;
            out_p   <= '0;
            spm_rst <= 1'b0;
`ifdef SPM_CTRL_ACCUM_EN
            acc_reg <= 1'b0;
            acc_ovf <= 1'b0;
`endif
        end else begin
            // Registered from next_state so spm leaves clear exactly on the first RUN cycle.
            spm_rst <= (next_state == RUN);
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    shreg <= '0;
                    if (in_valid) begin
                        a_reg   <= in_a;
                        x_reg   <= in_x;
`ifdef SPM_CTRL_ACCUM_EN
                        acc_reg <= in_acc;
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    // spm_y carries product bit cnt-1; nothing valid yet at cnt==0.
                    if (cnt != '0) begin
                        shreg <= {spm_y, shreg[2*bits-2:1]};
                    end
                    if (cnt == CNT_LAST) begin
`ifdef SPM_CTRL_ACCUM_EN
                        if (acc_reg) begin
                            out_p   <= acc_sum[2*bits-1:0];
                            acc_ovf <= acc_sum[2*bits];
                        end else begin
                            out_p   <= prod_next;
                            acc_ovf <= 1'b0;
                        end
`else
                        out_p <= prod_next;
`endif
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_ctrl.sv
// Bench for spm_ctrl: behavioural spm models feed two controllers (bits=4 and bits=32).
// A timestamp-based transaction model checks the 4-bit instance every cycle; directed
// vectors pin literal products and latencies on both instances.
module tb_spm_ctrl;
    localparam int B4  = 4;
    localparam int B32 = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        v4, r4, ov4, ordy4, busy4, srst4, sx4, sy4;
    logic [3:0]  a4, x4, sa4;
    logic [7:0]  p4;

    logic        v32, r32, ov32, ordy32, busy32, srst32, sx32, sy32;
    logic [31:0] a32, x32, sa32;
    logic [63:0] p32;

`ifdef SPM_CTRL_ACCUM_EN
    logic acc4, ovf4, acc32, ovf32;
`endif

    int checks = 0;
    int errors = 0;

    spm_ctrl #(.bits(B4)) d4 (
        .clk(clk), .rst(rst),
        .in_valid(v4), .in_ready(r4), .in_a(a4), .in_x(x4),
        .out_valid(ov4), .out_ready(ordy4), .out_p(p4),
        .busy(busy4), .spm_rst(srst4), .spm_a(sa4), .spm_x(sx4), .spm_y(sy4)
`ifdef SPM_CTRL_ACCUM_EN
        , .in_acc(acc4), .acc_ovf(ovf4)
`endif
    );

    spm_ctrl #(.bits(B32)) d32 (
        .clk(clk), .rst(rst),
        .in_valid(v32), .in_ready(r32), .in_a(a32), .in_x(x32),
        .out_valid(ov32), .out_ready(ordy32), .out_p(p32),
        .busy(busy32), .spm_rst(srst32), .spm_a(sa32), .spm_x(sx32), .spm_y(sy32)
`ifdef SPM_CTRL_ACCUM_EN
        , .in_acc(acc32), .acc_ovf(ovf32)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Serial/parallel multiplier: after the edge that shifts in x bit n, spm_y shows product bit n.
    function automatic logic y_of4(input logic [3:0] a, input logic [7:0] xs, input int n);
        logic [7:0] p;
        logic [7:0] t;
        p = {4'b0, a} * xs;
        t = p >> n;
        return t[0];
    endfunction

    function automatic logic y_of32(input logic [31:0] a, input logic [63:0] xs, input int n);
        logic [63:0] p;
        logic [63:0] t;
        p = {32'b0, a} * xs;
        t = p >> n;
        return t[0];
    endfunction

    function automatic logic xbit4(input logic [3:0] x, input int k);
        logic [3:0] t;
        if (k < 0 || k >= 4) return 1'b0;
        t = x >> k;
        return t[0];
    endfunction

    logic [7:0]  m4_xs = '0;
    int          m4_n  = 0;
    logic [63:0] m32_xs = '0;
    int          m32_n  = 0;

    always @(posedge clk) begin
        if (!srst4) begin
            m4_xs <= '0;
            m4_n  <= 0;
            sy4   <= 1'b0;
        end else begin
            m4_xs <= m4_xs | (8'(sx4) << m4_n);
            sy4   <= y_of4(sa4, m4_xs | (8'(sx4) << m4_n), m4_n);
            m4_n  <= m4_n + 1;
        end
    end

    always @(posedge clk) begin
        if (!srst32) begin
            m32_xs <= '0;
            m32_n  <= 0;
            sy32   <= 1'b0;
        end else begin
            m32_xs <= m32_xs | (64'(sx32) << m32_n);
            sy32   <= y_of32(sa32, m32_xs | (64'(sx32) << m32_n), m32_n);
            m32_n  <= m32_n + 1;
        end
    end

    // Transaction model for the 4-bit instance: an accepted pair occupies cycles
    // t0+1 .. t0+2B+1 in RUN and shows its result from cycle t0+2B+2 until taken.
    int         cyc    = 0;
    logic       m_pend = 1'b0;
    int         m_t0   = 0;
    logic [7:0] m_prod = '0;
    logic [7:0] m_outp = '0;
    logic       m_ovf  = 1'b0;
    logic       m_acc  = 1'b0;
    logic [3:0] m_a    = '0;
    logic [3:0] m_x    = '0;
    logic       chk_on = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_pend <= 1'b0;
            m_outp <= '0;
            m_ovf  <= 1'b0;
        end else if (!m_pend) begin
            if (v4) begin
                m_pend <= 1'b1;
                m_t0   <= cyc;
                m_prod <= {4'b0, a4} * {4'b0, x4};
                m_a    <= a4;
                m_x    <= x4;
`ifdef SPM_CTRL_ACCUM_EN
                m_acc  <= acc4;
`else
                m_acc  <= 1'b0;
`endif
            end
        end else if (cyc == m_t0 + 2*B4 + 1) begin
            {m_ovf, m_outp} <= m_acc ? ({1'b0, m_outp} + {1'b0, m_prod}) : {1'b0, m_prod};
        end else if (cyc >= m_t0 + 2*B4 + 2 && ordy4) begin
            m_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", r4, !m_pend);
            chk("busy", busy4, m_pend && (cyc <= m_t0 + 2*B4 + 1));
            chk("out_valid", ov4, m_pend && (cyc >= m_t0 + 2*B4 + 2));
            chk("spm_rst", srst4, m_pend && (cyc <= m_t0 + 2*B4 + 1));
            chk("out_p", p4, m_outp);
`ifdef SPM_CTRL_ACCUM_EN
            if (m_pend && (cyc >= m_t0 + 2*B4 + 2)) chk("acc_ovf", ovf4, m_ovf);
`endif
            if (m_pend && (cyc <= m_t0 + 2*B4 + 1)) begin
                chk("spm_a", sa4, m_a);
                chk("spm_x", sx4, xbit4(m_x, cyc - m_t0 - 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start4(input logic [3:0] a, input logic [3:0] x, input logic acc);
        a4 = a;
        x4 = x;
`ifdef SPM_CTRL_ACCUM_EN
        acc4 = acc;
`else
        if (acc) $display("note: accumulate request ignored in this build");
`endif
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
    endtask

    task automatic wait_valid4(output int lat);
        lat = 0;
        while (!ov4 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic start32(input logic [31:0] a, input logic [31:0] x);
        a32 = a;
        x32 = x;
        v32 = 1'b1;
        tick();
        v32 = 1'b0;
    endtask

    task automatic wait_valid32(output int lat);
        lat = 0;
        while (!ov32 && lat < 500) begin
            tick();
            lat++;
        end
    endtask

    int lat;
    int vq[$];
    int lows;

    initial begin
        rst = 1'b1;
        v4 = 1'b0; a4 = '0; x4 = '0; ordy4 = 1'b1;
        v32 = 1'b0; a32 = '0; x32 = '0; ordy32 = 1'b1;
`ifdef SPM_CTRL_ACCUM_EN
        acc4 = 1'b0; acc32 = 1'b0;
`endif
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_in_ready", r4, 1);
        chk("rst_out_valid", ov4, 0);
        chk("rst_out_p", p4, 0);
        chk("rst_spm_rst", srst4, 0);
        chk("rst_spm_a", sa4, 0);
        chk("rst_spm_x", sx4, 0);
        rst = 1'b0;
        tick();

        // 13 x 11 = 143 with a 9-cycle accept-to-valid latency.
        start4(4'd13, 4'd11, 1'b0);
        wait_valid4(lat);
        chk("lat_13x11", lat, 9);
        chk("p_13x11", p4, 8'h8F);
        tick();
        chk("idle_after_13x11", r4, 1);

        // 32-bit corner operands.
        start32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid32(lat);
        chk("lat_32", lat, 65);
        chk("p_ffxff", p32, 64'hFFFF_FFFE_0000_0001);
        tick();
        start32(32'h1, 32'h8000_0000);
        wait_valid32(lat);
        chk("p_1x8000", p32, 64'h8000_0000);
        tick();
        start32(32'h0, 32'h1234_5678);
        wait_valid32(lat);
        chk("p_zero32", p32, 64'h0);
        tick();

        // Result held under backpressure; a new request is not accepted meanwhile.
        ordy4 = 1'b0;
        start4(4'd15, 4'd15, 1'b0);
        wait_valid4(lat);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", ov4, 1);
            chk("hold_p", p4, 8'd225);
            chk("hold_in_ready", r4, 0);
            if (i == 4) begin
                a4 = 4'd3;
                x4 = 4'd3;
                v4 = 1'b1;
            end else begin
                v4 = 1'b0;
            end
            tick();
        end
        v4 = 1'b0;
        ordy4 = 1'b1;
        tick();
        chk("hold_released", ov4, 0);
        tick();
        chk("pulse_not_latched", busy4, 0);

        // Reset in the middle of a run.
        start4(4'd13, 4'd11, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", r4, 1);
        chk("abort_spm_rst", srst4, 0);
        chk("abort_valid", ov4, 0);
        start4(4'd5, 4'd7, 1'b0);
        wait_valid4(lat);
        chk("lat_5x7", lat, 9);
        chk("p_5x7", p4, 8'd35);
        tick();

        // Back-to-back with both handshakes held high.
        a4 = 4'd6;
        x4 = 4'd9;
        v4 = 1'b1;
        ordy4 = 1'b1;
        lows = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (ov4) begin
                vq.push_back(t);
                chk("b2b_p", p4, 8'd54);
            end
            if (vq.size() == 1 && !srst4) lows++;
        end
        v4 = 1'b0;
        chk("b2b_count", vq.size(), 3);
        if (vq.size() >= 3) begin
            chk("b2b_gap1", vq[1] - vq[0], 11);
            chk("b2b_gap2", vq[2] - vq[1], 11);
        end
        chk("b2b_spm_rst_gap", lows >= 1, 1);
        wait_valid4(lat);
        tick();
        tick();
        chk("drained", r4, 1);

`ifdef SPM_CTRL_ACCUM_EN
        start4(4'd15, 4'd15, 1'b0);
        wait_valid4(lat);
        chk("acc0_p", p4, 8'd225);
        chk("acc0_ovf", ovf4, 0);
        tick();
        start4(4'd15, 4'd15, 1'b1);
        wait_valid4(lat);
        chk("acc1_p", p4, 8'hC2);
        chk("acc1_ovf", ovf4, 1);
        tick();
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
